vip_itc_frame_counter_v2: RTL and testbench
===========================================

# vip_itc_frame_counter_v2

Parametrised raster position generator for the clocked-video output path of the VIP interface timing controller. It tracks horizontal and vertical position across a programmable frame. It is the next generation of the existing ITC frame counter and adds four capabilities:
- generic counter widths;
- 1/2/4/8 pixels-in-parallel stepping;
- frame-synchronous shadowing of new totals with a request/acknowledge handshake;
- optional interlaced field tracking.

## Interface
- `H_WIDTH`, 16: width of horizontal count and totals.
- `V_WIDTH`, 15: width of vertical count and totals.
- `NUMBER_OF_COLOUR_PLANES`, 3: colour planes per sample when sent in sequence.
- `COLOUR_PLANES_ARE_IN_PARALLEL`, 1: 1 means one sample per enabled cycle.
- `PIXELS_IN_PARALLEL`, 1: legal values are 1, 2, 4, 8.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous reset, active-high.
- `sclr` in 1: synchronous clear/preload.
- `enable` in 1: advance by one cycle of video.
- `par_mode` in 1: 1 = horizontal step of `PIXELS_IN_PARALLEL`; 0 = step of 1.
- `h_total` in H_WIDTH: pending line length in pixels (≥1).
- `v_total` in V_WIDTH: pending frame length in lines (≥1).
- `f1_v_start` in V_WIDTH: first line of field 1.
- `update_req` in 1: capture `h_total`/`v_total`/`f1_v_start` for the next frame.
- `update_ack` out 1: one-cycle pulse when captured values take effect.
- `h_reset` in H_WIDTH: preload value for `h_count` on `sclr`.
- `v_reset` in V_WIDTH: preload value for `v_count` on `sclr`.
- `count_sample` out 1: a full sample completes this cycle.
- `sample_tick` out clog2(NUMBER_OF_COLOUR_PLANES): index of the current colour plane.
- `new_line` out 1: last sample of the line.
- `new_frame` out 1: last sample of the frame.
- `h_count` out H_WIDTH: current horizontal position.
- `v_count` out V_WIDTH: current vertical position.
- `field` out 1: current field.

## Operation
- **Sample counting.** `sample_tick` counts 0..N-1 on `enable`, with N = `NUMBER_OF_COLOUR_PLANES`. If `COLOUR_PLANES_ARE_IN_PARALLEL`=1, `sample_tick` is fixed at 0.
  - `count_sample = enable & (parallel | sample_tick == N-1)`.
- **Active totals.** Active totals are held in registers `h_last = h_total-1` and `v_last = v_total-1`.
- **Horizontal step.** `h_step` = `par_mode ? PIXELS_IN_PARALLEL : 1`.
- **Line and frame detection.**
  - `new_line = count_sample & (h_count + h_step > h_last)`. The comparison is evaluated in H_WIDTH+1 bits so that it cannot overflow.
  - `new_frame = new_line & (v_count >= v_last)`.
- **Count update when `count_sample` is high:**
  - If `new_line`: `h_count`←0.
  - Otherwise: `h_count`←`h_count + h_step`.
  - On `new_line`: `v_count`←`new_frame` ? 0 : `v_count+1`.
- **Shadowing handshake.**
  - `update_req` copies the three inputs into pending registers and sets `pend`.
  - A further `update_req` while `pend` is set overwrites the pending values. Only one acknowledge is produced.
  - On `new_frame` with `pend` set: active values ← pending, `pend`←0, and `update_ack` pulses on the next cycle.
- **Synchronous clear (`sclr`).** `sclr` has priority over `enable`. It:
  - loads `h_count`←`h_reset` and `v_count`←`v_reset`;
  - clears `sample_tick`;
  - applies any pending values immediately and pulses `update_ack`;
  - recomputes `field` from `v_reset`.
- **Reset (`rst`).** Clears all registers, including `pend`, so a pending update is discarded.
  - Active totals reset to `h_last`=`v_last`=0, so every sample is both a line end and a frame end.
- **Out-of-range preload.** If `h_count > h_last` (for example after a preload beyond the total), the next sample wraps. The vertical count behaves the same way.

## Timing
- `h_count`, `v_count`, `field`, `sample_tick` and `update_ack` are registered. All reset to 0.
- `count_sample`, `new_line` and `new_frame` are combinational from registers and `enable`. They are 0 while `enable`=0.
- Counts update on the clock edge after `count_sample`.
- New totals govern the frame that starts on the edge that wraps `v_count` to 0.
- `update_req` and `new_frame` in the same cycle: the old pending value (if any) is applied. The request is then held for the following frame.

## Configuration
- **`VIP_FC_INTERLACE_EN` defined:** `field` is computed as follows.
  - It is set on the edge where `v_count` becomes `f1_v_start`.
  - It is cleared when `v_count` wraps to 0.
  - After `sclr`: `field = (v_reset >= f1_v_start)`.
  - An `f1_v_start` of 0 or greater than `v_last` keeps `field` at 0.
- **Not defined:** `field` is tied to 0, `f1_v_start` is ignored, and no pending or active copy of it is built.

## Structure
- **Package `vip_itc_pkg`:**
  - `PIP_LEGAL` check function;
  - `clog2` function;
  - typedefs `h_count_t` and `v_count_t`, parametrised via localparam defaults;
  - enum `par_mode_e` {`PM_SINGLE`, `PM_PARALLEL`}.
- **Sub-module `vip_itc_sample_counter`:** owns `sample_tick` and `count_sample`.
- The top level holds the position counters, the shadow registers and the field logic.

## Test plan
- **Sequential colour planes:** N=3, h_total=4, v_total=2, `enable` held high → `count_sample` every 3rd cycle; `new_line` at h_count=3; `new_frame` on the 24th enabled cycle.
- **Parallel stepping:** PIXELS_IN_PARALLEL=4, `par_mode`=1, h_total=10 → `h_count` sequence 0,4,8,0; `new_line` when h_count=8.
- **Update mid-frame:** `update_req` with h_total=6 mid-frame → old total holds until `new_frame`; `update_ack` pulses exactly once; the next line has length 6.
- **Preload:** `sclr` with h_reset=5, v_reset=1 while `enable`=1 → counts become 5/1 and `enable` is ignored for that cycle; a pending update is acknowledged.
- **Interlace (VIP_FC_INTERLACE_EN):** v_total=5, f1_v_start=3 → `field` goes 0→1 entering line 3 and 1→0 at the wrap; without the macro `field` stays 0.
- **Reset mid-operation:** assert `rst` mid-line with `pend` set → all outputs 0 asynchronously; no `update_ack` after release.

Source files
------------

// File: rtl/vip_itc_pkg.sv
// Shared types and elaboration helpers for the VIP ITC frame counter.
// Holds width defaults, the parallel-mode enum and parameter check functions.
package vip_itc_pkg;

  localparam int H_WIDTH_DEF = 16;
  localparam int V_WIDTH_DEF = 15;

  typedef logic [H_WIDTH_DEF-1:0] h_count_t;
  typedef logic [V_WIDTH_DEF-1:0] v_count_t;

  typedef enum logic {
    PM_SINGLE   = 1'b0,
    PM_PARALLEL = 1'b1
  } par_mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // sample_tick keeps at least one bit so a single plane still elaborates
  function automatic int tick_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit pip_legal(input int p);
    return (p == 1) || (p == 2) || (p == 4) || (p == 8);
  endfunction

endpackage

// File: rtl/vip_itc_sample_counter.sv
// Colour-plane sequencer: steps sample_tick through the planes of a sample.
// Ports: clk, rst, sclr, enable in; sample_tick, count_sample out.
module vip_itc_sample_counter
  import vip_itc_pkg::*;
#(
  parameter int N        = 3,
  parameter int PARALLEL = 1,
  parameter int TW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclr,
  input  logic          enable,
  output logic [TW-1:0] sample_tick,
  output logic          count_sample
);

  localparam logic PAR = (PARALLEL != 0) || (N < 2);
  localparam logic [TW-1:0] LAST = TW'(N - 1);

  logic at_last;

  assign at_last = (sample_tick == LAST);

  // sclr wins over enable, so a clear cycle never completes a sample
  assign count_sample = enable & ~sclr & (PAR | at_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_tick <= '0;
    end else if (sclr) begin
      sample_tick <= '0;
    end else if (enable && !PAR) begin
      sample_tick <= at_last ? '0 : sample_tick + TW'(1);
    end
  end

endmodule

// File: rtl/vip_itc_frame_counter_v2.sv
// Raster position generator with shadowed totals and optional field tracking.
// Ports: clk, rst, sclr, enable, par_mode, totals, update_req/ack, presets,
// count_sample, sample_tick, new_line, new_frame, h_count, v_count, field.
// Build option: define VIP_FC_INTERLACE_EN to enable interlaced field tracking.
module vip_itc_frame_counter_v2
  import vip_itc_pkg::*;
#(
  parameter int H_WIDTH                       = 16,
  parameter int V_WIDTH                       = 15,
  parameter int NUMBER_OF_COLOUR_PLANES       = 3,
  parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 1,
  parameter int PIXELS_IN_PARALLEL            = 1,
  localparam int TW = tick_width(NUMBER_OF_COLOUR_PLANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclr,
  input  logic               enable,
  input  logic               par_mode,
  input  logic [H_WIDTH-1:0] h_total,
  input  logic [V_WIDTH-1:0] v_total,
  input  logic [V_WIDTH-1:0] f1_v_start,
  input  logic               update_req,
  output logic               update_ack,
  input  logic [H_WIDTH-1:0] h_reset,
  input  logic [V_WIDTH-1:0] v_reset,
  output logic               count_sample,
  output logic [TW-1:0]      sample_tick,
  output logic               new_line,
  output logic               new_frame,
  output logic [H_WIDTH-1:0] h_count,
  output logic [V_WIDTH-1:0] v_count,
  output logic               field
);

  // illegal widths fall back to single-pixel stepping
  localparam int PIP = pip_legal(PIXELS_IN_PARALLEL) ?
                       PIXELS_IN_PARALLEL : 1;
  localparam logic [H_WIDTH:0] STEP_P = (H_WIDTH+1)'(PIP);
  localparam logic [H_WIDTH:0] STEP_1 = (H_WIDTH+1)'(1);

  logic [H_WIDTH-1:0] h_last;
  logic [V_WIDTH-1:0] v_last;
  logic [H_WIDTH-1:0] pend_h;
  logic [V_WIDTH-1:0] pend_v;
  logic               pend;
  logic               apply;
  logic [H_WIDTH:0]   h_step;
  logic [H_WIDTH:0]   h_sum;

  vip_itc_sample_counter #(
    .N        (NUMBER_OF_COLOUR_PLANES),
    .PARALLEL (COLOUR_PLANES_ARE_IN_PARALLEL),
    .TW       (TW)
  ) u_sample (
    .clk          (clk),
    .rst          (rst),
    .sclr         (sclr),
    .enable       (enable),
    .sample_tick  (sample_tick),
    .count_sample (count_sample)
  );

  assign h_step = (par_mode_e'(par_mode) == PM_PARALLEL) ? STEP_P : STEP_1;

  // one spare bit so a position near the top of the range cannot wrap
  assign h_sum     = {1'b0, h_count} + h_step;
  assign new_line  = count_sample & (h_sum > {1'b0, h_last});
  assign new_frame = new_line & (v_count >= v_last);

  assign apply = pend & (sclr | new_frame);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (sclr) begin
      h_count <= h_reset;
      v_count <= v_reset;
    end else if (count_sample) begin
      if (new_line) begin
        h_count <= '0;
        v_count <= new_frame ? '0 : v_count + V_WIDTH'(1);
      end else begin
        h_count <= h_sum[H_WIDTH-1:0];
      end
    end
  end

  // a request landing on the frame edge is kept for the following frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= 1'b0;
      pend_h     <= '0;
      pend_v     <= '0;
      h_last     <= '0;
      v_last     <= '0;
      update_ack <= 1'b0;
    end else begin
      update_ack <= apply;
      if (apply) begin
        h_last <= pend_h;
        v_last <= pend_v;
      end
      if (update_req) begin
        pend_h <= h_total - H_WIDTH'(1);
        pend_v <= v_total - V_WIDTH'(1);
        pend   <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef VIP_FC_INTERLACE_EN

  logic [V_WIDTH-1:0] pend_f1;
  logic [V_WIDTH-1:0] f1_act;
  logic [V_WIDTH-1:0] f1_eff;
  logic [V_WIDTH-1:0] vl_eff;

  function automatic logic f1_ok(input logic [V_WIDTH-1:0] f1,
                                 input logic [V_WIDTH-1:0] vl);
    return (f1 != '0) && (f1 <= vl);
  endfunction

  // on a clear the field must see the totals being applied that cycle
  assign f1_eff = apply ? pend_f1 : f1_act;
  assign vl_eff = apply ? pend_v : v_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_f1 <= '0;
      f1_act  <= '0;
    end else begin
      if (apply) f1_act <= pend_f1;
      if (update_req) pend_f1 <= f1_v_start;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field <= 1'b0;
    end else if (sclr) begin
      field <= f1_ok(f1_eff, vl_eff) && (v_reset >= f1_eff);
    end else if (new_line) begin
      if (new_frame) begin
        field <= 1'b0;
      end else if (f1_ok(f1_act, v_last) &&
                   ((v_count + V_WIDTH'(1)) == f1_act)) begin
        field <= 1'b1;
      end
    end
  end

`else

  logic unused_f1;

  assign unused_f1 = ^f1_v_start;
  assign field     = 1'b0;

`endif

endmodule

// File: tb/tb_vip_itc_frame_counter_v2.sv
// Self-checking bench for vip_itc_frame_counter_v2.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_vip_itc_frame_counter_v2;

  localparam int HW  = 8;
  localparam int VW  = 6;
  localparam int N   = 3;
  localparam int PIP = 4;
  localparam int TW  = 2;
`ifdef VIP_FC_INTERLACE_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          sclr = 1'b0;
  logic          enable = 1'b0;
  logic          par_mode = 1'b0;
  logic [HW-1:0] h_total = '0;
  logic [VW-1:0] v_total = '0;
  logic [VW-1:0] f1_v_start = '0;
  logic          update_req = 1'b0;
  logic          update_ack;
  logic [HW-1:0] h_reset = '0;
  logic [VW-1:0] v_reset = '0;
  logic          count_sample;
  logic [TW-1:0] sample_tick;
  logic          new_line;
  logic          new_frame;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          field;

  vip_itc_frame_counter_v2 #(
    .H_WIDTH                       (HW),
    .V_WIDTH                       (VW),
    .NUMBER_OF_COLOUR_PLANES       (N),
    .COLOUR_PLANES_ARE_IN_PARALLEL (0),
    .PIXELS_IN_PARALLEL            (PIP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sclr         (sclr),
    .enable       (enable),
    .par_mode     (par_mode),
    .h_total      (h_total),
    .v_total      (v_total),
    .f1_v_start   (f1_v_start),
    .update_req   (update_req),
    .update_ack   (update_ack),
    .h_reset      (h_reset),
    .v_reset      (v_reset),
    .count_sample (count_sample),
    .sample_tick  (sample_tick),
    .new_line     (new_line),
    .new_frame    (new_frame),
    .h_count      (h_count),
    .v_count      (v_count),
    .field        (field)
  );

  int checks = 0;
  int passed = 0;

  // model: raster position, active/pending "last index" values, ack
  int m_tick, m_h, m_v, m_hl, m_vl, m_f1;
  int m_ph, m_pv, m_pf1;
  bit m_pend, m_ack;

  function automatic void model_reset();
    m_tick = 0; m_h = 0; m_v = 0; m_hl = 0; m_vl = 0; m_f1 = 0;
    m_ph = 0; m_pv = 0; m_pf1 = 0; m_pend = 0; m_ack = 0;
  endfunction

  function automatic int m_step();
    return par_mode ? PIP : 1;
  endfunction

  function automatic bit m_cs();
    return enable && !sclr && (m_tick == N - 1);
  endfunction

  function automatic bit m_nl();
    return m_cs() && (m_h + m_step() > m_hl);
  endfunction

  function automatic bit m_nf();
    return m_nl() && (m_v >= m_vl);
  endfunction

  // field is 1 on every line from f1 to the end of the frame
  function automatic bit m_field();
    if (!IL) return 1'b0;
    return (m_f1 >= 1) && (m_f1 <= m_vl) && (m_v >= m_f1);
  endfunction

  task automatic clk_step();
    bit cs, nl, nf, ap;
    int st;
    @(posedge clk);
    cs = m_cs(); nl = m_nl(); nf = m_nf(); st = m_step();
    ap = m_pend && (sclr || nf);
    m_ack = ap;
    if (sclr) begin
      m_h = h_reset; m_v = v_reset; m_tick = 0;
    end else if (enable) begin
      m_tick = (m_tick + 1) % N;
      if (cs) begin
        if (nl) begin
          m_h = 0;
          m_v = nf ? 0 : (m_v + 1) % (1 << VW);
        end else begin
          m_h = m_h + st;
        end
      end
    end
    if (ap) begin
      m_hl = m_ph; m_vl = m_pv; m_f1 = m_pf1;
    end
    if (update_req) begin
      m_ph = (int'(h_total) + (1 << HW) - 1) % (1 << HW);
      m_pv = (int'(v_total) + (1 << VW) - 1) % (1 << VW);
      m_pf1 = f1_v_start; m_pend = 1;
    end else if (ap) begin
      m_pend = 0;
    end
    @(negedge clk);
    sclr = 1'b0;
    update_req = 1'b0;
  endtask

  task automatic program_totals(input int ht, input int vt, input int f1,
                                input int hr, input int vr);
    enable = 1'b0;
    update_req = 1'b1;
    h_total = HW'(ht); v_total = VW'(vt); f1_v_start = VW'(f1);
    clk_step();
    sclr = 1'b1;
    h_reset = HW'(hr); v_reset = VW'(vr);
    clk_step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({h_count, v_count, sample_tick, update_ack, field} !== '0)
      $display("FAIL reset_regs: got h=%0d v=%0d t=%0d a=%0d f=%0d exp 0",
               h_count, v_count, sample_tick, update_ack, field);
    else passed++;
    checks++;
    if ({count_sample, new_line, new_frame} !== 3'b000)
      $display("FAIL reset_comb: got %b exp 000",
               {count_sample, new_line, new_frame});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_colour_planes();
    int s;
    par_mode = 1'b0;
    program_totals(4, 2, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      enable = 1'b1;
      #1;
      s = i / 3;
      checks++;
      if (count_sample !== (i % 3 == 2))
        $display("FAIL cp_count_sample[%0d]: got %0d exp %0d",
                 i, count_sample, (i % 3 == 2));
      else passed++;
      checks++;
      if (int'(h_count) != s % 4 || int'(v_count) != (s / 4) % 2)
        $display("FAIL cp_pos[%0d]: got %0d/%0d exp %0d/%0d",
                 i, h_count, v_count, s % 4, (s / 4) % 2);
      else passed++;
      checks++;
      if (new_line !== (i % 3 == 2 && s % 4 == 3))
        $display("FAIL cp_new_line[%0d]: got %0d", i, new_line);
      else passed++;
      checks++;
      if (new_frame !== (i == 23))
        $display("FAIL cp_new_frame[%0d]: got %0d exp %0d",
                 i, new_frame, (i == 23));
      else passed++;
      checks++;
      if (update_ack !== (i == 0))
        $display("FAIL cp_ack[%0d]: got %0d exp %0d", i, update_ack, (i == 0));
      else passed++;
      clk_step();
    end
  endtask

  task automatic test_parallel();
    int seq [4];
    seq = '{0, 4, 8, 0};
    par_mode = 1'b1;
    program_totals(10, 2, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      enable = 1'b1;
      #1;
      if (i % 3 == 2) begin
        checks++;
        if (int'(h_count) != seq[i / 3])
          $display("FAIL par_h[%0d]: got %0d exp %0d",
                   i / 3, h_count, seq[i / 3]);
        else passed++;
        checks++;
        if (new_line !== (seq[i / 3] == 8))
          $display("FAIL par_new_line[%0d]: got %0d", i / 3, new_line);
        else passed++;
      end
      clk_step();
    end
    par_mode = 1'b0;
  endtask

  task automatic test_update_mid_frame();
    int first_nf, acks, ack_at, nl_after, h_at;
    par_mode = 1'b0;
    program_totals(4, 2, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      enable = 1'b1;
      clk_step();
    end
    first_nf = -1; acks = 0; ack_at = -1; nl_after = -1; h_at = -1;
    for (int i = 0; i < 60; i++) begin
      enable = 1'b1;
      if (i == 0) begin
        update_req = 1'b1;
        h_total = HW'(6); v_total = VW'(2);
      end
      #1;
      if (new_frame && first_nf < 0) first_nf = i;
      if (update_ack) begin
        acks++;
        ack_at = i;
      end
      if (new_line && first_nf >= 0 && i > first_nf && nl_after < 0) begin
        nl_after = i;
        h_at = h_count;
      end
      clk_step();
    end
    checks++;
    if (first_nf != 8)
      $display("FAIL upd_frame_end: got %0d exp 8", first_nf);
    else passed++;
    checks++;
    if (acks != 1 || ack_at != 9)
      $display("FAIL upd_ack: got %0d pulses at %0d exp 1 at 9", acks, ack_at);
    else passed++;
    checks++;
    if (nl_after != 26 || h_at != 5)
      $display("FAIL upd_new_len: got line end %0d h=%0d exp 26 h=5",
               nl_after, h_at);
    else passed++;
  endtask

  task automatic test_preload();
    par_mode = 1'b0;
    enable = 1'b0;
    update_req = 1'b1;
    h_total = HW'(7); v_total = VW'(3);
    clk_step();
    sclr = 1'b1; enable = 1'b1;
    h_reset = HW'(5); v_reset = VW'(1);
    clk_step();
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1;
      #1;
      if (i == 0) begin
        checks++;
        if (int'(h_count) != 5 || int'(v_count) != 1 || sample_tick !== '0)
          $display("FAIL pre_load: got h=%0d v=%0d t=%0d exp 5/1/0",
                   h_count, v_count, sample_tick);
        else passed++;
      end
      checks++;
      if (update_ack !== (i == 0))
        $display("FAIL pre_ack[%0d]: got %0d exp %0d", i, update_ack, (i == 0));
      else passed++;
      checks++;
      if (new_line !== (i == 5) || new_frame !== 1'b0)
        $display("FAIL pre_line[%0d]: got nl=%0d nf=%0d", i, new_line, new_frame);
      else passed++;
      clk_step();
    end
  endtask

  task automatic test_boundaries();
    par_mode = 1'b1;
    program_totals(255, 1, 0, 252, 0);
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1;
      #1;
      if (i == 2) begin
        checks++;
        if (int'(h_count) != 252 || !new_line || !new_frame)
          $display("FAIL bnd_top: got h=%0d nl=%0d nf=%0d exp 252/1/1",
                   h_count, new_line, new_frame);
        else passed++;
      end
      if (i == 3) begin
        checks++;
        if (h_count !== '0)
          $display("FAIL bnd_top_wrap: got %0d exp 0", h_count);
        else passed++;
      end
      clk_step();
    end
    par_mode = 1'b0;
    program_totals(4, 2, 0, 200, 9);
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1;
      #1;
      if (i == 2) begin
        checks++;
        if (!new_line || !new_frame)
          $display("FAIL bnd_oor: got nl=%0d nf=%0d exp 1/1",
                   new_line, new_frame);
        else passed++;
      end
      if (i == 3) begin
        checks++;
        if (h_count !== '0 || v_count !== '0)
          $display("FAIL bnd_oor_wrap: got %0d/%0d exp 0/0", h_count, v_count);
        else passed++;
      end
      clk_step();
    end
  endtask

  task automatic test_interlace();
    int v;
    par_mode = 1'b0;
    program_totals(2, 5, 3, 0, 0);
    for (int i = 0; i < 33; i++) begin
      enable = 1'b1;
      #1;
      v = ((i / 3) / 2) % 5;
      checks++;
      if (int'(v_count) != v || field !== (IL && v >= 3))
        $display("FAIL il_field[%0d]: got v=%0d f=%0d exp v=%0d f=%0d",
                 i, v_count, field, v, (IL && v >= 3));
      else passed++;
      clk_step();
    end
    enable = 1'b0;
    sclr = 1'b1;
    h_reset = '0; v_reset = VW'(4);
    clk_step();
    #1;
    checks++;
    if (field !== IL)
      $display("FAIL il_sclr: got %0d exp %0d", field, IL);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom % 4) != 0;
      sclr = ($urandom % 40) == 0;
      update_req = ($urandom % 15) == 0;
      par_mode = $urandom % 2;
      h_total = HW'(1 + $urandom % 12);
      v_total = VW'(1 + $urandom % 6);
      f1_v_start = VW'($urandom % 7);
      h_reset = HW'($urandom % 16);
      v_reset = VW'($urandom % 8);
      #1;
      checks++;
      if (count_sample !== m_cs() || int'(sample_tick) != m_tick)
        $display("FAIL rnd_sample[%0d]: got %0d/%0d exp %0d/%0d",
                 i, count_sample, sample_tick, m_cs(), m_tick);
      else passed++;
      checks++;
      if (new_line !== m_nl() || new_frame !== m_nf())
        $display("FAIL rnd_edges[%0d]: got %0d/%0d exp %0d/%0d",
                 i, new_line, new_frame, m_nl(), m_nf());
      else passed++;
      checks++;
      if (int'(h_count) != m_h || int'(v_count) != m_v)
        $display("FAIL rnd_pos[%0d]: got %0d/%0d exp %0d/%0d",
                 i, h_count, v_count, m_h, m_v);
      else passed++;
      checks++;
      if (update_ack !== m_ack || field !== m_field())
        $display("FAIL rnd_ack_field[%0d]: got %0d/%0d exp %0d/%0d",
                 i, update_ack, field, m_ack, m_field());
      else passed++;
      clk_step();
    end
    sclr = 1'b0;
    update_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    par_mode = 1'b0;
    program_totals(50, 10, 0, 0, 0);
    enable = 1'b0;
    update_req = 1'b1;
    h_total = HW'(3); v_total = VW'(3);
    clk_step();
    for (int i = 0; i < 7; i++) begin
      enable = 1'b1;
      clk_step();
    end
    enable = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({h_count, v_count, sample_tick, update_ack, field} !== '0)
      $display("FAIL rstmid_regs: got h=%0d v=%0d t=%0d a=%0d exp 0",
               h_count, v_count, sample_tick, update_ack);
    else passed++;
    checks++;
    if ({count_sample, new_line, new_frame} !== 3'b000)
      $display("FAIL rstmid_comb: got %b exp 000",
               {count_sample, new_line, new_frame});
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      enable = 1'b1;
      #1;
      checks++;
      if (update_ack !== 1'b0 || h_count !== '0 || new_frame !== (i % 3 == 2))
        $display("FAIL rstmid_after[%0d]: got a=%0d h=%0d nf=%0d exp 0/0/%0d",
                 i, update_ack, h_count, new_frame, (i % 3 == 2));
      else passed++;
      clk_step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_colour_planes();
    test_parallel();
    test_update_mid_frame();
    test_preload();
    test_boundaries();
    test_interlace();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
